// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: drives the PC register,
// runs the imem request/ready handshake, buffers one fetch across ID stalls, flushes on redirect.
module if_fetch_stage #(
    parameter int unsigned size      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] pc_current,
    output logic [size-1:0] pc_next,
    output logic            pc_write_enable,
    input  logic            stall_id,
    input  logic            flush,
    input  logic [size-1:0] redirect_target,
    output logic            imem_req,
    output logic [size-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [size-1:0] if_id_pc,
    output logic [size-1:0] if_id_pc_plus4,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid
);

    localparam logic [size-1:0] PC_INC     = size'(4);
    localparam logic [size-1:0] ALIGN_MASK = ~size'(3);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // What the IF/ID register does at the next edge
    typedef enum logic [2:0] {
        LD_KEEP   = 3'd0,
        LD_FETCH  = 3'd1,
        LD_BUF    = 3'd2,
        LD_BUBBLE = 3'd3,
        LD_FLUSH  = 3'd4
    } ld_sel_t;

    state_t          state, state_nxt;
    ld_sel_t         ld_sel;
    logic            buf_capture;
    logic [size-1:0] hold_pc;
    logic [31:0]     hold_instr;

    assign imem_addr = pc_current;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    // Next state, PC control and IF/ID load selection; flush > stall > normal
    always_comb begin
        state_nxt       = state;
        pc_next         = pc_current + PC_INC;
        pc_write_enable = 1'b0;
        imem_req        = 1'b0;
        ld_sel          = LD_KEEP;
        buf_capture     = 1'b0;
        if (flush) begin
            pc_next         = redirect_target & ALIGN_MASK;
            pc_write_enable = 1'b1;
            ld_sel          = LD_FLUSH;
            state_nxt       = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        pc_write_enable = 1'b1;
                        if (stall_id) begin
                            buf_capture = 1'b1;
                            state_nxt   = HOLD;
                        end else begin
                            ld_sel = LD_FETCH;
                        end
                    end else if (!stall_id) begin
                        ld_sel = LD_BUBBLE;
                    end
                end
                HOLD: begin
                    if (!stall_id) begin
                        ld_sel    = LD_BUF;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    // One-entry hold buffer; a flush discards its contents
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
        end else if (ld_sel == LD_FLUSH) begin
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
        end else if (buf_capture) begin
            hold_pc    <= pc_current;
            hold_instr <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_instr    <= NOP_INSTR;
            if_id_valid    <= 1'b0;
        end else begin
            case (ld_sel)
                LD_FETCH: begin
                    if_id_pc       <= pc_current;
                    if_id_pc_plus4 <= pc_current + PC_INC;
                    if_id_instr    <= imem_rdata;
                    if_id_valid    <= 1'b1;
                end
                LD_BUF: begin
                    if_id_pc       <= hold_pc;
                    if_id_pc_plus4 <= hold_pc + PC_INC;
                    if_id_instr    <= hold_instr;
                    if_id_valid    <= 1'b1;
                end
                LD_BUBBLE: begin
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                end
                LD_FLUSH: begin
                    if_id_pc       <= '0;
                    if_id_pc_plus4 <= '0;
                    if_id_instr    <= NOP_INSTR;
                    if_id_valid    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the segmented RISC-V core. Sits between the PC register and the decode stage. Drives the PC register's next value and write enable, runs the instruction-memory request/ready handshake, and presents a registered {pc, pc+4, instruction, valid} bundle to ID. Handles decode stalls with a one-entry hold buffer and EX-stage branch/jump redirects with a flush.

## Interface
Parameters:
- `size`, 32, datapath/address width.
- `NOP_INSTR`, 32'h00000013, instruction word loaded into IF/ID on reset/flush/bubble (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_current`  in  size  PC register output.
- `pc_next`  out  size  next PC value, to PC register input.
- `pc_write_enable`  out  1  PC register write enable.
- `stall_id`  in  1  ID cannot accept a new instruction; IF/ID must hold.
- `flush`  in  1  taken branch/jump resolved in EX; redirect to `redirect_target`.
- `redirect_target`  in  size  branch/jump target.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  size  request address.
- `imem_rdata`  in  32  instruction word; valid when `imem_ready`=1.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle.
- `if_id_pc`  out  size  PC of the instruction in IF/ID.
- `if_id_pc_plus4`  out  size  `if_id_pc` + 4.
- `if_id_instr`  out  32  instruction word.
- `if_id_valid`  out  1  IF/ID holds a real instruction.

## Operation
- FSM states: FETCH, HOLD. Reset state: FETCH.
- Combinational outputs: `imem_addr` = `pc_current`. `imem_req` = 1 in FETCH and 0 in HOLD, and also 0 in any cycle with `flush`=1. `pc_next` = `pc_current` + 4 (mod 2^size) unless `flush`=1, in which case `pc_next` = `redirect_target` with bits [1:0] forced to 0.
- Priority: flush > stall > normal.
- flush=1, in any state: `pc_write_enable`=1. At the next edge: IF/ID is loaded with valid=0 and instr=`NOP_INSTR`, with pc fields 0; the hold buffer is discarded; the state goes to FETCH. `imem_rdata` in that cycle is ignored.
- FETCH, `imem_ready`=1, `stall_id`=0: `pc_write_enable`=1. IF/ID is loaded with {`pc_current`, `pc_current`+4, `imem_rdata`, valid=1}. State stays FETCH.
- FETCH, `imem_ready`=1, `stall_id`=1: `pc_write_enable`=1. {pc, `imem_rdata`} is captured into the hold buffer. IF/ID holds. State goes to HOLD.
- FETCH, `imem_ready`=0, `stall_id`=0: `pc_write_enable`=0. A bubble is loaded into IF/ID (valid=0, instr=`NOP_INSTR`, pc fields hold). State stays FETCH.
- FETCH, `imem_ready`=0, `stall_id`=1: `pc_write_enable`=0. Everything holds.
- HOLD, `stall_id`=1: `pc_write_enable`=0, `imem_req`=0. Everything holds.
- HOLD, `stall_id`=0: `pc_write_enable`=0. IF/ID is loaded from the hold buffer with valid=1. State goes to FETCH. The PC already points to the following instruction.
- Each fetched instruction enters IF/ID exactly once. No duplicates, no drops, except on flush.

## Timing
- Reset (async assert, active-low): `if_id_pc`=0, `if_id_pc_plus4`=0, `if_id_instr`=`NOP_INSTR`, `if_id_valid`=0, hold buffer cleared, state FETCH. Combinational outputs follow their equations (`imem_req`=1, `imem_addr`=`pc_current`).
- Zero-wait memory (`imem_ready` tied to 1): one instruction per cycle. Fetch-to-IF/ID latency is 1 cycle.
- N wait cycles produce N bubbles in IF/ID.
- Flush: the target is fetched the cycle after `flush`. The first valid IF/ID entry from the target appears 2 cycles after the `flush` cycle (zero-wait).
- Reset asserted mid-HOLD or mid-wait: the buffered instruction is lost. Restart from FETCH.
- `imem_req` can drop while a request is outstanding (flush or HOLD). Memory abandons the request; a later `imem_ready` without `imem_req` is ignored.

## Test plan
- Reset, then `imem_ready`=1, memory returns `addr`|0xA000: IF/ID shows pc 0,4,8,... on successive cycles with instr 0xA000,0xA004,..., valid=1, and `if_id_pc_plus4`=`if_id_pc`+4.
- `imem_ready` low for 2 cycles at PC=0x8: two bubbles (valid=0, instr=0x00000013), then pc 0x8 valid, with no PC advance during the wait.
- `stall_id`=1 for 3 cycles while FETCH gets ready at PC=0x10: PC advances once to 0x14, `imem_req`=0 during HOLD, IF/ID holds the old entry, then shows 0x10 on the release cycle and 0x14 on the next.
- `flush`=1 with `redirect_target`=0x103 while `stall_id`=1 in HOLD: `pc_next`=0x100, IF/ID valid=0 next cycle, buffer discarded, then pc 0x100 valid.
- `flush` and `imem_ready` in the same cycle at PC=0x20: data for 0x20 never appears valid in IF/ID.
- Reset asserted asynchronously mid-HOLD: outputs reach reset values before the next clock edge, and fetch resumes from the PC register value.
